// File: rtl/fibo_majority_pkg.sv
// rtl/fibo_majority_pkg.sv - shared constants, types and Fibonacci test for the majority sequencer
package fibo_majority_pkg;

    localparam int NUM_W      = 4;
    localparam int FRAME_LEN  = 13;
    localparam int MAJ_THRESH = 7;

    typedef logic [NUM_W-1:0] num_t;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Fibonacci numbers representable in 4 bits: 0,1,2,3,5,8,13
    function automatic logic is_fibo(num_t n);
        case (n)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13: is_fibo = 1'b1;
            default:                                   is_fibo = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/majority13.sv
// rtl/majority13.sv - combinational 13-input Fibonacci-majority vote
module majority13
    import fibo_majority_pkg::*;
(
    input  num_t nums [FRAME_LEN],
    output logic majority
);

    logic [3:0] cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (is_fibo(nums[i])) begin
                cnt = cnt + 4'd1;
            end
        end
        majority = (cnt >= 4'(MAJ_THRESH));
    end

endmodule

// File: rtl/fibo_majority_seq.sv
// rtl/fibo_majority_seq.sv - buffers 13 streamed numbers and presents a registered majority verdict
module fibo_majority_seq
    import fibo_majority_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [NUM_W-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_majority,
    output logic [3:0]       out_hits
);

    seq_state_t state, state_nxt;
    num_t       frame_buf [FRAME_LEN];
    logic [3:0] idx;
    logic [3:0] hits;
    logic       maj_c;
    logic       accept;

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DONE);
    // abort outranks a simultaneous input beat
    assign accept    = in_valid & in_ready & ~abort;

    majority13 u_majority13 (
        .nums     (frame_buf),
        .majority (maj_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD: if (accept && idx == 4'(FRAME_LEN - 1)) state_nxt = EVAL;
                EVAL: state_nxt = DONE;
                DONE: if (out_ready) state_nxt = LOAD;
                default: state_nxt = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx          <= '0;
            hits         <= '0;
            out_majority <= 1'b0;
            out_hits     <= '0;
            frame_buf    <= '{default: '0};
        end else if (abort) begin
            idx  <= '0;
            hits <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        frame_buf[idx] <= in_data;
                        idx            <= idx + 4'd1;
                        if (is_fibo(in_data)) begin
                            hits <= hits + 4'd1;
                        end
                    end
                end
                EVAL: begin
                    out_majority <= maj_c;
                    out_hits     <= hits;
                end
                DONE: begin
                    if (out_ready) begin
                        idx  <= '0;
                        hits <= '0;
                    end
                end
                default: begin
                    idx  <= '0;
                    hits <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fibo_majority_seq.sv
// tb/tb_fibo_majority_seq.sv - directed and randomized checks of fibo_majority_seq against a counting model
module tb_fibo_majority_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       abort;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       out_majority;
    logic [3:0] out_hits;

    int checks;
    int errors;

    logic [3:0] frame [13];

    fibo_majority_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_majority (out_majority),
        .out_hits     (out_hits)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_hits(input logic [3:0] v [13]);
        int n = 0;
        foreach (v[i]) if (v[i] inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13}) n++;
        return n;
    endfunction

    task automatic set_frame(input int v [13]);
        foreach (v[i]) frame[i] = 4'(v[i]);
    endtask

    task automatic push(input logic [3:0] v, input int gap);
        int t = 0;
        in_valid = 1'b0;
        repeat (gap) step();
        in_data  = v;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) chk("push_timeout_in_ready", {3'b0, in_ready}, 4'd1);
        step();
    endtask

    // streams a frame, then checks the EVAL cycle and the verdict
    task automatic load_frame(input int maxgap);
        int h;
        h = model_hits(frame);
        for (int i = 0; i < 13; i++) push(frame[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
        in_valid = 1'b0;
        chk("eval_in_ready", {3'b0, in_ready}, 4'd0);
        chk("eval_out_valid", {3'b0, out_valid}, 4'd0);
        step();
        chk("verdict_valid", {3'b0, out_valid}, 4'd1);
        chk("verdict_hits", out_hits, 4'(h));
        chk("verdict_majority", {3'b0, out_majority}, {3'b0, (h >= 7)});
        chk("cross_check", {3'b0, out_majority}, {3'b0, (out_hits >= 4'd7)});
    endtask

    task automatic take_verdict(input int hold);
        logic       m0;
        logic [3:0] h0;
        m0 = out_majority;
        h0 = out_hits;
        out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_data  = 4'($urandom_range(0, 15));
            step();
            chk("hold_valid", {3'b0, out_valid}, 4'd1);
            chk("hold_in_ready", {3'b0, in_ready}, 4'd0);
            chk("hold_majority", {3'b0, out_majority}, {3'b0, m0});
            chk("hold_hits", out_hits, h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("handshake_out_valid", {3'b0, out_valid}, 4'd0);
        chk("handshake_in_ready", {3'b0, in_ready}, 4'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        chk("reset_in_ready", {3'b0, in_ready}, 4'd1);
        chk("reset_out_valid", {3'b0, out_valid}, 4'd0);
        chk("reset_majority", {3'b0, out_majority}, 4'd0);
        chk("reset_hits", out_hits, 4'd0);

        // 13 x 5, continuous handshake
        foreach (frame[i]) frame[i] = 4'd5;
        out_ready = 1'b1;
        load_frame(0);
        chk("all5_hits", out_hits, 4'd13);
        take_verdict(0);

        // threshold boundary: exactly 7 hits, then 6 hits
        set_frame('{1, 2, 3, 5, 8, 13, 0, 4, 6, 7, 9, 10, 11});
        load_frame(0);
        chk("thr7_majority", {3'b0, out_majority}, 4'd1);
        take_verdict(0);
        set_frame('{0, 1, 2, 3, 5, 8, 4, 6, 7, 9, 10, 11, 12});
        load_frame(0);
        chk("thr6_majority", {3'b0, out_majority}, 4'd0);
        // verdict held for 5 cycles with in_valid asserted
        take_verdict(5);

        // abort after 6 accepts, coinciding with an input beat
        for (int i = 0; i < 6; i++) push(4'($urandom_range(0, 15)), 0);
        in_data  = 4'd1;
        in_valid = 1'b1;
        abort    = 1'b1;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_in_ready", {3'b0, in_ready}, 4'd1);
        chk("abort_out_valid", {3'b0, out_valid}, 4'd0);
        foreach (frame[i]) frame[i] = 4'd4;
        load_frame(0);
        chk("all4_majority", {3'b0, out_majority}, 4'd0);
        chk("all4_hits", out_hits, 4'd0);
        take_verdict(1);

        // reset while a verdict is pending
        foreach (frame[i]) frame[i] = 4'($urandom_range(0, 15));
        load_frame(1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_done_out_valid", {3'b0, out_valid}, 4'd0);
        chk("rst_done_in_ready", {3'b0, in_ready}, 4'd1);
        chk("rst_done_hits", out_hits, 4'd0);
        foreach (frame[i]) frame[i] = 4'd8;
        load_frame(0);
        chk("all8_majority", {3'b0, out_majority}, 4'd1);
        chk("all8_hits", out_hits, 4'd13);
        take_verdict(0);

        // randomized frames with gaps and back-pressure
        for (int f = 0; f < 24; f++) begin
            foreach (frame[i]) frame[i] = ($urandom_range(0, 1) == 1) ?
                4'($urandom_range(0, 15)) : 4'($urandom_range(4, 7));
            load_frame(2);
            take_verdict($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
